alu_seq: RTL and testbench

//  Parametrised, registered ALU with a valid/ready handshake. Next generation of the 8-bit combinational ALU.

---
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshake and iterative shift-add multiplier.
// Define ALU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle multiply.
module alu_seq #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcase,
  input  logic [SHW-1:0]   shiftamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum, diff;
  logic             z, gt, c, v, is_cmp, sub_v, accept;
`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
`else
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [SHW-1:0]     cnt;
  logic               is_mul;
`endif

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    sub_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    res    = '0;
    gt     = 1'b0;
    c      = 1'b0;
    v      = 1'b0;
    is_cmp = 1'b0;
`ifdef ALU_FAST_MUL_EN
    prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
    case (opcase[2:0])
      3'b000: res = ~a;
      3'b001: res = a & b;
      3'b010: res = a | b;
      3'b011: begin
        if (opcase[3]) begin
          is_cmp = 1'b1;
          gt     = (a > b);
          c      = ~diff[WIDTH];
          v      = sub_v;
        end else begin
`ifdef ALU_FAST_MUL_EN
          res = prod[WIDTH-1:0];
          c   = |prod[2*WIDTH-1:WIDTH];
`endif
        end
      end
      3'b100: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b101: begin
        res = diff[WIDTH-1:0];
        c   = ~diff[WIDTH];
        v   = sub_v;
      end
      3'b110: res = opcase[3] ? $unsigned($signed(a) >>> shiftamt) : (a >> shiftamt);
      // Rotate: (a >> 1) >> ~s equals a >> (WIDTH - s) for s > 0 and yields 0 for s == 0.
      3'b111: res = opcase[3] ? ((a << shiftamt) | ((a >> 1) >> ~shiftamt)) : (a << shiftamt);
      default: res = '0;
    endcase
    z = is_cmp ? (a == b) : (res == '0);
  end

`ifndef ALU_FAST_MUL_EN
  assign is_mul  = (opcase == 4'b0011);
  assign acc_nxt = acc + (mplier[cnt] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out1      <= '0;
      flags     <= '0;
`ifndef ALU_FAST_MUL_EN
      acc       <= '0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else if (accept) begin
`ifndef ALU_FAST_MUL_EN
      if (is_mul) begin
        state     <= MUL_BUSY;
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        mcand     <= a;
        mplier    <= b;
      end else
`endif
      begin
        state     <= DONE;
        out_valid <= 1'b1;
        out1      <= res;
        flags     <= {v, c, gt, z};
      end
    end else begin
      case (state)
`ifndef ALU_FAST_MUL_EN
        MUL_BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out1      <= acc_nxt[WIDTH-1:0];
            flags     <= {1'b0, |acc_nxt[2*WIDTH-1:WIDTH], 1'b0, ~|acc_nxt[WIDTH-1:0]};
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] opcase = '0;
  logic [2:0] shiftamt = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out1;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcase(opcase), .shiftamt(shiftamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] sh);
    opcase = op; a = va; b = vb; shiftamt = sh; in_valid = 1'b1;
  endtask

  // flags expectation is {V, C, GT, Z}
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input logic [2:0] sh,
                        input logic [7:0] eo, input logic [3:0] ef);
    drive(op, va, vb, sh);
    chk({tag, "_rdy"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_out"}, out1, eo);
    chk({tag, "_flg"}, flags, ef);
  endtask

  task automatic mul_run(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] eo, input logic [3:0] ef);
    int cyc;
    drive(4'b0011, va, vb, 3'd0);
    step();
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      chk({tag, "_busy"}, in_ready, 0);
      step();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, MUL_LAT);
    chk({tag, "_out"}, out1, eo);
    chk({tag, "_flg"}, flags, ef);
  endtask

  initial begin
    step();
    chk("rst_vld", out_valid, 0);
    chk("rst_out", out1, 0);
    chk("rst_flg", flags, 0);
    step();
    rst = 1'b0;
    chk("rst_rdy", in_ready, 1);

    out_ready = 1'b1;
    run_op("add_wrap", 4'b0100, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0101);
    run_op("sub_ovf",  4'b0101, 8'h80, 8'h01, 3'd0, 8'h7F, 4'b1100);
    run_op("cmp_eq",   4'b1011, 8'h05, 8'h05, 3'd0, 8'h00, 4'b0101);
    run_op("cmp_gt",   4'b1011, 8'h07, 8'h03, 3'd0, 8'h00, 4'b0110);
    run_op("cmp_lt",   4'b1011, 8'h03, 8'h07, 3'd0, 8'h00, 4'b0000);
    run_op("and",      4'b0001, 8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000);
    run_op("or",       4'b1010, 8'hF0, 8'h0C, 3'd0, 8'hFC, 4'b0000);
    run_op("not",      4'b0000, 8'hFF, 8'h00, 3'd0, 8'h00, 4'b0001);
    run_op("add_ovf",  4'b0100, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b1000);
    run_op("sub_brw",  4'b0101, 8'h03, 8'h05, 3'd0, 8'hFE, 4'b0000);
    run_op("asr",      4'b1110, 8'h90, 8'h00, 3'd3, 8'hF2, 4'b0000);
    run_op("rol",      4'b1111, 8'h81, 8'h00, 3'd1, 8'h03, 4'b0000);
    run_op("rol0",     4'b1111, 8'hB4, 8'h00, 3'd0, 8'hB4, 4'b0000);
    run_op("shr0",     4'b0110, 8'h90, 8'h00, 3'd0, 8'h90, 4'b0000);
    run_op("shr4",     4'b0110, 8'h90, 8'h00, 3'd4, 8'h09, 4'b0000);
    run_op("shl3",     4'b0111, 8'h81, 8'h00, 3'd3, 8'h08, 4'b0000);

    step();
    chk("idle_vld", out_valid, 0);
    mul_run("mul",    8'h12, 8'h10, 8'h20, 4'b0100);
    mul_run("mul0",   8'h00, 8'h55, 8'h00, 4'b0001);
    mul_run("mulmax", 8'hFF, 8'hFF, 8'h01, 4'b0100);

    step();
    out_ready = 1'b0;
    drive(4'b0100, 8'h10, 8'h20, 3'd0);
    step();
    drive(4'b0101, 8'h30, 8'h10, 3'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", out_valid, 1);
      chk("bp_out", out1, 8'h30);
      chk("bp_flg", flags, 4'b0000);
      chk("bp_rdy", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_up", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp2_vld", out_valid, 1);
    chk("bp2_out", out1, 8'h20);
    chk("bp2_flg", flags, 4'b0100);
    step();
    chk("bp_idle", out_valid, 0);

    drive(4'b0011, 8'h12, 8'h10, 3'd0);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_out", out1, 0);
    chk("mrst_flg", flags, 0);
    step();
    rst = 1'b0;
    chk("mrst_rdy", in_ready, 1);
    run_op("add_post", 4'b0100, 8'h02, 8'h03, 3'd0, 8'h05, 4'b0000);
    for (int i = 0; i < 12; i++) step();
    chk("post_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
